// File: rtl/simple_pkg.sv
// Shared constants for the execute/write-back stage: condition codes,
// {S,Z,C,V} bit positions and default datapath/register-address widths.
package simple_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  localparam int SZCV_S = 3;
  localparam int SZCV_Z = 2;
  localparam int SZCV_C = 1;
  localparam int SZCV_V = 0;

  localparam logic [3:0] CC_BE   = 4'h0;
  localparam logic [3:0] CC_BLT  = 4'h1;
  localparam logic [3:0] CC_BLE  = 4'h2;
  localparam logic [3:0] CC_BNE  = 4'h3;
  localparam logic [3:0] CC_BCS  = 4'h4;
  localparam logic [3:0] CC_B    = 4'h7;
  localparam logic [3:0] CC_NONE = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over the {S,Z,C,V} flag register.
module cond_eval
  import simple_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] br_cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_cond)
      CC_BE:   taken = flags[SZCV_Z];
      CC_BLT:  taken = flags[SZCV_S] ^ flags[SZCV_V];
      CC_BLE:  taken = flags[SZCV_Z] | (flags[SZCV_S] ^ flags[SZCV_V]);
      CC_BNE:  taken = ~flags[SZCV_Z];
      CC_BCS:  taken = flags[SZCV_C];
      CC_B:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/write-back stage: holds one register write, owns the flag register
// and resolves branches. Define FWD_PATH_EN to drive the fwd_* bypass outputs.
module ex_wb_stage
  import simple_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_szcv,
  input  logic              set_flags,
  input  logic              wr_req,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic [3:0]        br_cond,
  input  logic [DATA_W-1:0] br_target,
  input  logic              flush,
  input  logic              out_ready,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  // Handshake: an instruction transfers when in_valid && in_ready; a held
  // write retires when wb_valid && out_ready. flush vetoes the transfer.
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [3:0]        flags_q, flags_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_addr_q, br_addr_d;
  logic              accept;
  logic              cond_taken;

  assign in_ready = !wb_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Evaluated against the flags before this instruction's own update.
  cond_eval u_cond_eval (
    .flags   (flags_q),
    .br_cond (br_cond),
    .taken   (cond_taken)
  );

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;
    br_taken_d = 1'b0;
    br_addr_d  = br_addr_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else begin
      if (wb_valid_q && out_ready) wb_valid_d = 1'b0;
      if (accept && wr_req) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = dst_reg;
        wb_data_d  = alu_res;
      end
      if (accept && set_flags) flags_d = alu_szcv;
      if (accept && cond_taken) begin
        br_taken_d = 1'b1;
        br_addr_d  = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= 4'h0;
      br_taken_q <= 1'b0;
      br_addr_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
      br_taken_q <= br_taken_d;
      br_addr_q  <= br_addr_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flags    = flags_q;
  assign br_taken = br_taken_q;
  assign br_addr  = br_addr_q;

`ifdef FWD_PATH_EN
  assign fwd_valid = wb_valid_q;
  assign fwd_addr  = wb_addr_q;
  assign fwd_data  = wb_data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_ex_wb_stage;
  import simple_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 0, in_ready;
  logic [DW-1:0] alu_res = '0;
  logic [3:0]    alu_szcv = '0;
  logic          set_flags = 0, wr_req = 0;
  logic [AW-1:0] dst_reg = '0;
  logic [3:0]    br_cond = 4'hF;
  logic [DW-1:0] br_target = '0;
  logic          flush = 0, out_ready = 0;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [3:0]    flags;
  logic          br_taken;
  logic [DW-1:0] br_addr;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  ex_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .alu_szcv(alu_szcv), .set_flags(set_flags),
    .wr_req(wr_req), .dst_reg(dst_reg), .br_cond(br_cond),
    .br_target(br_target), .flush(flush), .out_ready(out_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .br_taken(br_taken), .br_addr(br_addr),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one pending write slot, a flag register, last branch
  function automatic bit branch_rule(input logic [3:0] f, input logic [3:0] cc);
    bit s, z, c, v;
    {s, z, c, v} = f;
    if (cc == 4'd0) return z;
    if (cc == 4'd1) return s != v;
    if (cc == 4'd2) return z || (s != v);
    if (cc == 4'd3) return !z;
    if (cc == 4'd4) return c;
    if (cc == 4'd7) return 1;
    return 0;
  endfunction

  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [3:0]    m_flags;
  logic          m_taken;
  logic [DW-1:0] m_baddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_addr <= '0; m_data <= '0;
      m_flags <= '0; m_taken <= 0; m_baddr <= '0;
    end else if (flush) begin
      m_valid <= 0;
      m_taken <= 0;
    end else begin
      bit room, took, br;
      room = !m_valid || out_ready;
      took = in_valid && room;
      br   = took && branch_rule(m_flags, br_cond);
      m_taken <= br;
      if (br) m_baddr <= br_target;
      if (took && set_flags) m_flags <= alu_szcv;
      if (took && wr_req) begin
        m_valid <= 1; m_addr <= dst_reg; m_data <= alu_res;
      end else if (out_ready) begin
        m_valid <= 0;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_in_ready", in_ready, !m_valid || out_ready);
      check("cmp_wb_valid", wb_valid, m_valid);
      check("cmp_wb_addr", wb_addr, m_addr);
      check("cmp_wb_data", wb_data, m_data);
      check("cmp_flags", flags, m_flags);
      check("cmp_br_taken", br_taken, m_taken);
      check("cmp_br_addr", br_addr, m_baddr);
`ifdef FWD_PATH_EN
      check("cmp_fwd", {fwd_valid, fwd_addr, fwd_data}, {m_valid, m_addr, m_data});
`else
      check("cmp_fwd", {fwd_valid, fwd_addr, fwd_data}, '0);
`endif
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] res, input logic [3:0] szcv,
                       input bit sf, input bit wr, input logic [AW-1:0] dst,
                       input logic [3:0] cc, input logic [DW-1:0] tgt,
                       input bit fl, input bit ordy);
    in_valid = v; alu_res = res; alu_szcv = szcv; set_flags = sf; wr_req = wr;
    dst_reg = dst; br_cond = cc; br_target = tgt; flush = fl; out_ready = ordy;
  endtask

  task automatic idle(input bit ordy);
    drive(0, '0, '0, 0, 0, '0, CC_NONE, '0, 0, ordy);
  endtask

  initial begin
    idle(0);
    repeat (3) step();
    chk_en = 1;
    check("reset_wb_valid", wb_valid, 0);
    check("reset_flags", flags, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1;

    // single write, accepted on the first edge after reset release
    drive(1, 16'h1234, 4'h0, 0, 1, 3'd5, CC_NONE, '0, 0, 1);
    step();
    check("wr_valid", wb_valid, 1);
    check("wr_addr", wb_addr, 5);
    check("wr_data", wb_data, 16'h1234);

    // back-pressure: entry held three cycles, then replaced without a bubble
    drive(1, 16'hABCD, 4'h0, 0, 1, 3'd2, CC_NONE, '0, 0, 0);
    #1 check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_data_stable", wb_data, 16'h1234);
    end
    out_ready = 1;
    #1 check("bp_in_ready_rel", in_ready, 1);
    step();
    check("bp_new_valid", wb_valid, 1);
    check("bp_new_data", wb_data, 16'hABCD);
    check("bp_new_addr", wb_addr, 2);
    idle(1);
    step();
    check("bp_drained", wb_valid, 0);

    // CMP then BE (taken) then BNE (not taken)
    drive(1, '0, 4'b0100, 1, 0, '0, CC_NONE, '0, 0, 1);
    step();
    check("cmp_flags_lit", flags, 4'b0100);
    drive(1, '0, '0, 0, 0, '0, CC_BE, 16'h0040, 0, 1);
    step();
    check("be_taken", br_taken, 1);
    check("be_addr", br_addr, 16'h0040);
    drive(1, '0, '0, 0, 0, '0, CC_BNE, 16'h0080, 0, 1);
    step();
    check("be_one_cycle", br_taken, 0);
    idle(1);
    step();
    check("bne_taken", br_taken, 0);
    check("bne_addr", br_addr, 16'h0040);

    // ordering: branch sees the old flags, update lands afterwards
    drive(1, '0, 4'b0000, 1, 0, '0, CC_NONE, '0, 0, 1);
    step();
    drive(1, '0, 4'b0100, 1, 0, '0, CC_BE, 16'h0100, 0, 1);
    step();
    check("ord_taken", br_taken, 0);
    check("ord_flags", flags, 4'b0100);

    // flush kills the held entry, the flag update and the branch
    drive(1, 16'h5555, '0, 0, 1, 3'd1, CC_NONE, '0, 0, 0);
    step();
    drive(1, 16'h7777, 4'b1011, 1, 1, 3'd3, CC_B, 16'h0200, 1, 0);
    step();
    check("fl_wb_valid", wb_valid, 0);
    check("fl_flags", flags, 4'b0100);
    check("fl_br_taken", br_taken, 0);

    // asynchronous reset in the middle of a held write and a taken branch
    drive(1, 16'h9999, '0, 0, 1, 3'd6, CC_B, 16'h0300, 0, 0);
    step();
    idle(0);
    check("pre_rst_valid", wb_valid, 1);
    check("pre_rst_taken", br_taken, 1);
    #2 rst_n = 0;
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_flags", flags, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_br_addr", br_addr, 0);
    step();
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, DW'($urandom), 4'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0, AW'($urandom),
            ($urandom_range(0, 3) == 0) ? CC_NONE : 4'($urandom_range(0, 15)),
            DW'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      step();
    end
    idle(1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
